bus_interconnect: RTL
=====================

BUS_INTERCONNECT -- requirements
Module: bus_interconnect

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of master ports, range 1-8.
REQ-002 Parameter NUM_SLAVES, default 4: number of slave ports, range 1-16.
REQ-003 Parameter SLAVE_REGION, default {4'hF,4'h2,4'h1,4'h0}: addr[31:28] region of each slave, index 0 in the LSBs.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: cycles from bstart to completion before a timeout error; 0 disables the timeout.
REQ-005 Port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Ports m_breq/m_bstart, input, [NUM_MASTERS]: per-master bus request and transfer-start pulse.
REQ-008 Ports m_addr/m_wdata, input, [NUM_MASTERS][32]; m_tsize, input, [NUM_MASTERS][2]: per-master transfer fields.
REQ-009 Ports m_bgnt/m_bdone/m_berror, output, [NUM_MASTERS]: grant, completion pulse and error pulse per master.
REQ-010 Port m_rdata, output, [NUM_MASTERS][32]: read data for the master.
REQ-011 Ports s_ss/s_bstart, output, [NUM_SLAVES]: slave select and start pulse per slave.
REQ-012 Ports s_addr/s_wdata, output, 32; s_tsize, output, 2: shared slave-side transfer fields.
REQ-013 Ports s_bdone, input, [NUM_SLAVES]; s_rdata, input, [NUM_SLAVES][32]: per-slave completion and read data.

Function
REQ-014 Arbiter states SHALL be IDLE, GRANTED, BUSY and ERR.
- IDLE: no owner.
- GRANTED: owner holds m_bgnt and no transfer has started.
- BUSY: a transfer is outstanding.
- ERR: one-cycle berror response.
REQ-015 In IDLE with any m_breq high, the arbiter SHALL pick one requester round-robin, starting the search after the last owner; m_bgnt SHALL be registered and high on the next cycle.
REQ-016 Exactly one m_bgnt bit SHALL be high at any time, or none.
REQ-017 In GRANTED, an m_bstart from the owner SHALL move to BUSY; m_bstart from a non-owner SHALL be ignored.
REQ-018 Decode SHALL be combinational on the owner's addr[31:28] against SLAVE_REGION. The lowest-index match wins.
REQ-019 In GRANTED and BUSY, the matching s_ss SHALL be high, and s_addr/s_wdata/s_tsize SHALL carry the owner's fields.
REQ-020 s_bstart SHALL be the owner's m_bstart, routed only to the matching slave.
REQ-021 In BUSY, the selected s_bdone SHALL be forwarded combinationally as m_bdone of the owner, with s_rdata on m_rdata in the same cycle.
REQ-022 A bstart with no matching region SHALL go to ERR. m_berror SHALL pulse for one cycle, the cycle after bstart, and no s_ss or s_bstart is asserted.
REQ-023 In BUSY, a cycle counter SHALL increment from 0. On reaching TIMEOUT_CYCLES without s_bdone, the block SHALL go to ERR and pulse m_berror once.
REQ-024 A late s_bdone after a timeout SHALL be dropped.
REQ-025 After bdone or berror, the next state SHALL be GRANTED if the owner's m_breq is high and no other master requests; otherwise the block SHALL go to IDLE and re-arbitrate the following cycle.
REQ-026 A transfer SHALL never be pre-empted.
REQ-027 If the owner deasserts m_breq in GRANTED, the block SHALL return to IDLE next cycle.
REQ-028 If the owner deasserts m_breq in BUSY, the transfer SHALL still complete.
REQ-029 When no owner exists, m_rdata SHALL be 0, m_bdone/m_berror 0 and s_* outputs 0.
REQ-030 If s_bdone and the timeout coincide, bdone SHALL win.

Reset
REQ-031 On rst high, immediately and asynchronously, the state SHALL be IDLE.
REQ-032 On reset, all m_bgnt/m_bdone/m_berror/s_ss/s_bstart SHALL be 0, the counter 0 and the round-robin pointer set to master NUM_MASTERS-1, so master 0 has first priority.
REQ-033 Reset during BUSY SHALL abandon the transfer with no bdone or berror issued.
REQ-034 The first grant SHALL be possible on the second rising edge after rst deasserts.

Structure
REQ-035 Package bus_pkg SHALL hold tsize_t (BYTE/HALF/WORD), the arb_state_t enum, the region-decode function and the default SLAVE_REGION constant.
REQ-036 Sub-module rr_arbiter SHALL be parametrised by NUM_MASTERS: requests, enable and last-owner in; one-hot grant out.
REQ-037 All other logic SHALL be flat in bus_interconnect.

Verification
REQ-038 Single-master read: m0 reads addr 0xF000_0010, slave 3 returns bdone after 2 cycles with rdata 0xDEADBEEF -> m0 bgnt one cycle after breq, s_ss[3]=1 and m_rdata=0xDEADBEEF with m_bdone.
REQ-039 Contention: m0 and m1 request continuously, one access each -> grants alternate m0, m1, m0, with no cycle where both bgnt are high.
REQ-040 Unmapped access: m1 bstart to 0x5000_0000 -> m_berror[1] high one cycle later, all s_ss low, arbiter back to IDLE.
REQ-041 Timeout: TIMEOUT_CYCLES=8, the slave never sends bdone -> m_berror exactly 8 cycles after bstart; a later s_bdone produces no m_bdone.
REQ-042 Reset mid-transfer: rst pulsed while BUSY -> all outputs 0 in the same cycle, and m0 is granted first after release even if m1 also requests.
REQ-043 Coincidence: s_bdone arrives on the timeout cycle -> m_bdone asserted and m_berror stays low.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types, default address map and region decode for the bus interconnect.
package bus_pkg;

    typedef enum logic [1:0] {TsByte, TsHalf, TsWord} tsize_t;

    typedef enum logic [1:0] {StIdle, StGranted, StBusy, StErr} arb_state_t;

    localparam int MaxSlaves = 16;

    localparam logic [15:0] DEFAULT_SLAVE_REGION = {4'hF, 4'h2, 4'h1, 4'h0};

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } decode_t;

    // Lowest-index slave whose region nibble matches wins.
    function automatic decode_t region_decode(input logic [4*MaxSlaves-1:0] regions,
                                              input int num_slaves,
                                              input logic [3:0] region);
        decode_t res;
        res.hit = 1'b0;
        res.idx = 4'd0;
        for (int i = 0; i < MaxSlaves; i++) begin
            if (!res.hit && i < num_slaves && regions[4*i +: 4] == region) begin
                res.hit = 1'b1;
                res.idx = 4'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: searches upward from the master after the last owner.
module rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   enable,
    input  logic [IDX_W-1:0]       last,
    output logic [NUM_MASTERS-1:0] gnt
);

    int         idx;
    logic       found;
    logic [IDX_W-1:0] pos;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        pos   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(last) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            pos = IDX_W'(idx);
            if (enable && !found && req[pos]) begin
                gnt[pos] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_interconnect.sv
// Multi-master, multi-slave shared bus with round-robin ownership, address decode,
// unmapped-access errors and a per-transfer timeout.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int                      NUM_MASTERS    = 2,
    parameter int                      NUM_SLAVES     = 4,
    parameter logic [4*NUM_SLAVES-1:0] SLAVE_REGION   = DEFAULT_SLAVE_REGION,
    parameter int unsigned             TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] m_breq,
    input  logic [NUM_MASTERS-1:0] m_bstart,
    input  logic [31:0]            m_addr   [NUM_MASTERS],
    input  logic [31:0]            m_wdata  [NUM_MASTERS],
    input  tsize_t                 m_tsize  [NUM_MASTERS],
    output logic [NUM_MASTERS-1:0] m_bgnt,
    output logic [NUM_MASTERS-1:0] m_bdone,
    output logic [NUM_MASTERS-1:0] m_berror,
    output logic [31:0]            m_rdata  [NUM_MASTERS],
    output logic [NUM_SLAVES-1:0]  s_ss,
    output logic [NUM_SLAVES-1:0]  s_bstart,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output tsize_t                 s_tsize,
    input  logic [NUM_SLAVES-1:0]  s_bdone,
    input  logic [31:0]            s_rdata  [NUM_SLAVES]
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [MW-1:0] LastInit = MW'(NUM_MASTERS - 1);
    localparam logic [4*MaxSlaves-1:0] RegionPad = (4*MaxSlaves)'(SLAVE_REGION);

    arb_state_t state_q, state_d;
    logic [MW-1:0] owner_q, owner_d;
    logic [MW-1:0] last_q, last_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          ready_q;

    logic [NUM_MASTERS-1:0] arb_gnt;
    logic [NUM_MASTERS-1:0] owner_oh;
    logic [MW-1:0]          gnt_idx;
    decode_t                dec;
    logic [SW-1:0]          slave_idx;
    logic                   sel;
    logic                   keep;
    logic                   timeout_hit;

    // Arbitration is held off for one edge after reset so the first grant lands on the second.
    rr_arbiter #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (MW)
    ) u_arb (
        .req   (m_breq),
        .enable(ready_q && state_q == StIdle),
        .last  (last_q),
        .gnt   (arb_gnt)
    );

    always_comb begin
        gnt_idx  = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (arb_gnt[i]) gnt_idx = MW'(i);
        end
        owner_oh[owner_q] = 1'b1;
    end

    assign dec       = region_decode(RegionPad, NUM_SLAVES, m_addr[owner_q][31:28]);
    assign slave_idx = SW'(dec.idx);
    assign sel       = dec.hit && (state_q == StGranted || state_q == StBusy);
    assign keep      = m_breq[owner_q] && !(|(m_breq & ~owner_oh));

    // Fires on the last BUSY cycle so berror lands TIMEOUT_CYCLES cycles after bstart;
    // a bdone in that same cycle still takes priority.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q + 32'd2 >= TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= LastInit;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (|arb_gnt) begin
                    state_d = StGranted;
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                end
            end
            StGranted: begin
                if (!m_breq[owner_q]) begin
                    state_d = StIdle;
                end else if (m_bstart[owner_q]) begin
                    state_d = dec.hit ? StBusy : StErr;
                end
            end
            StBusy: begin
                if (dec.hit && s_bdone[slave_idx]) begin
                    state_d = keep ? StGranted : StIdle;
                end else if (timeout_hit) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StErr: begin
                state_d = keep ? StGranted : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_bgnt   = '0;
        m_bdone  = '0;
        m_berror = '0;
        s_ss     = '0;
        s_bstart = '0;
        s_addr   = '0;
        s_wdata  = '0;
        s_tsize  = TsByte;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rdata[i] = '0;
        end
        if (state_q != StIdle) begin
            m_bgnt[owner_q] = 1'b1;
        end
        if (sel) begin
            s_ss[slave_idx]     = 1'b1;
            s_addr              = m_addr[owner_q];
            s_wdata             = m_wdata[owner_q];
            s_tsize             = m_tsize[owner_q];
            s_bstart[slave_idx] = (state_q == StGranted) && m_breq[owner_q] && m_bstart[owner_q];
        end
        if (sel && state_q == StBusy && s_bdone[slave_idx]) begin
            m_bdone[owner_q] = 1'b1;
            m_rdata[owner_q] = s_rdata[slave_idx];
        end
        if (state_q == StErr) begin
            m_berror[owner_q] = 1'b1;
        end
    end

endmodule
